// File: rtl/bcd_down_ct_pkg.sv
// Shared constants and helpers for the BCD down counter and its digit slices.
package bcd_down_ct_pkg;

    localparam int              BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Non-decimal nibbles are forced to 9 so a digit can never hold 10..15.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_ct_digit.sv
// One BCD decade of the down counter: clamped load, decrement with 0 -> 9 wrap,
// and a ripple borrow to the next more significant digit.
module bcd_down_digit
    import bcd_down_ct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    logic [BCD_W-1:0] digit_d;
    logic [BCD_W-1:0] digit_q;

    always_comb begin
        // NOTE: default first, so every path assigns digit_d and no latch is inferred.
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_digit);
        end else if (borrow_in) begin
            digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = borrow_in && (digit_q == '0);

endmodule

// File: rtl/bcd_down_ct.sv
// Loadable multi-digit BCD down counter with a zero flag and a registered
// one-cycle borrow pulse when the count wraps from all-zero to all-nines.
module bcd_down_ct
    import bcd_down_ct_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    input  logic                    en,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                    zero,
    output logic                    borrow
);

    logic [DIGITS:0] borrow_chain;
    logic            borrow_d;
    logic            borrow_q;

    // In saturate mode an all-zero count must not start a ripple, or every digit would flip to 9.
    assign borrow_chain[0] = en && !load && ((WRAP != 0) || !zero);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_val[i*BCD_W +: BCD_W]),
            .borrow_in  (borrow_chain[i]),
            .digit      (q[i*BCD_W +: BCD_W]),
            .borrow_out (borrow_chain[i+1])
        );
    end

    assign zero = (q == '0);

    always_comb begin
        borrow_d = (WRAP != 0) && borrow_chain[DIGITS];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            borrow_q <= 1'b0;
        end else begin
            borrow_q <= borrow_d;
        end
    end

    assign borrow = borrow_q;

endmodule

// File: tb/tb_bcd_down_ct.sv
// Scoreboard bench: a wrapping and a saturating counter share stimulus; expected
// results are queued by the driver and popped by an independent monitor.
module tb_bcd_down_ct;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       en;
    logic [7:0] load_val;
    logic [7:0] q_w, q_s;
    logic       zero_w, zero_s;
    logic       borrow_w, borrow_s;

    typedef struct {
        string      name;
        logic [7:0] qw;
        logic       bw;
        logic [7:0] qs;
        logic       bs;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    always #5 clk = ~clk;

    bcd_down_ct #(.DIGITS(2), .WRAP(1)) dut_wrap (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .q(q_w), .zero(zero_w), .borrow(borrow_w)
    );

    bcd_down_ct #(.DIGITS(2), .WRAP(0)) dut_sat (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .q(q_s), .zero(zero_s), .borrow(borrow_s)
    );

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got q=%h zero=%b borrow=%b, expected q=%h zero=%b borrow=%b",
                     name, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic push(input string name, input logic [7:0] qw, input logic bw,
                        input logic [7:0] qs, input logic bs);
        exp_t x;
        x.name = name;
        x.qw   = qw;
        x.bw   = bw;
        x.qs   = qs;
        x.bs   = bs;
        sb.push_back(x);
    endtask

    // Drive one clock of stimulus and queue the state expected after that edge.
    task automatic step(input string name, input logic ld, input logic [7:0] v, input logic e,
                        input logic [7:0] qw, input logic bw, input logic [7:0] qs, input logic bs);
        @(negedge clk);
        load     = ld;
        load_val = v;
        en       = e;
        @(posedge clk);
        #1;
        push(name, qw, bw, qs, bs);
    endtask

    // Reset asserted mid-cycle must clear the outputs before any clock edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        load = 1'b0;
        en   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        push(name, 8'h00, 1'b0, 8'h00, 1'b0);
        ->sample_ev;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk or sample_ev);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check({mon_e.name, "/wrap"}, {q_w, zero_w, borrow_w},
                      {mon_e.qw, mon_e.qw == 8'h00, mon_e.bw});
                check({mon_e.name, "/sat"}, {q_s, zero_s, borrow_s},
                      {mon_e.qs, mon_e.qs == 8'h00, mon_e.bs});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [7:0] down_tbl [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                                  8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    initial begin : stimulus
        reset    = 1'b1;
        load     = 1'b0;
        en       = 1'b0;
        load_val = 8'h00;
        @(negedge clk);
        #1;
        push("reset_state", 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset in the middle of a count.
        step("load47", 1'b1, 8'h47, 1'b0, 8'h47, 1'b0, 8'h47, 1'b0);
        async_reset("async_reset47");
        step("hold_after_reset", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Count down from 12 through zero and past it.
        step("load12", 1'b1, 8'h12, 1'b0, 8'h12, 1'b0, 8'h12, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step($sformatf("count12_%0d", i), 1'b0, 8'h00, 1'b1,
                 down_tbl[i], 1'b0, down_tbl[i], 1'b0);
        end
        step("wrap_99", 1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0);
        step("borrow_clears", 1'b0, 8'h00, 1'b0, 8'h99, 1'b0, 8'h00, 1'b0);
        step("after_wrap", 1'b0, 8'h00, 1'b1, 8'h98, 1'b0, 8'h00, 1'b0);

        // Saturation versus wrap with continuous enable.
        step("load02", 1'b1, 8'h02, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0);
        step("sat_01", 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0);
        step("sat_00", 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        step("sat_hold0", 1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0);
        step("sat_hold1", 1'b0, 8'h00, 1'b1, 8'h98, 1'b0, 8'h00, 1'b0);
        step("sat_hold2", 1'b0, 8'h00, 1'b1, 8'h97, 1'b0, 8'h00, 1'b0);

        // Load wins over enable; load also clears a pending borrow.
        step("pre_wrap", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step("wrap_again", 1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0);
        step("load50_en", 1'b1, 8'h50, 1'b1, 8'h50, 1'b0, 8'h50, 1'b0);
        step("dec49", 1'b0, 8'h00, 1'b1, 8'h49, 1'b0, 8'h49, 1'b0);

        // Non-decimal nibbles clamp per digit.
        step("clampA3", 1'b1, 8'hA3, 1'b0, 8'h93, 1'b0, 8'h93, 1'b0);
        step("clamp3F", 1'b1, 8'h3F, 1'b0, 8'h39, 1'b0, 8'h39, 1'b0);
        step("clampFF", 1'b1, 8'hFF, 1'b0, 8'h99, 1'b0, 8'h99, 1'b0);

        // Enable gating, then reset recovery into an immediate wrap.
        step("load30", 1'b1, 8'h30, 1'b0, 8'h30, 1'b0, 8'h30, 1'b0);
        step("gate_en1", 1'b0, 8'h00, 1'b1, 8'h29, 1'b0, 8'h29, 1'b0);
        step("gate_en0", 1'b0, 8'h00, 1'b0, 8'h29, 1'b0, 8'h29, 1'b0);
        step("gate_en1b", 1'b0, 8'h00, 1'b1, 8'h28, 1'b0, 8'h28, 1'b0);
        async_reset("async_reset28");
        step("recover_wrap", 1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0);
        step("recover_hold", 1'b0, 8'h00, 1'b0, 8'h99, 1'b0, 8'h00, 1'b0);

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 5; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
